// File: rtl/layer_mac_scheduler.sv
// Time-multiplexed MAC controller for one fully-connected layer: one shared datapath walks every node.
// Optional build macro LAYER_SCHED_SAT_EN saturates positive results that overflow the Q-slice.
module layer_mac_scheduler #(
  parameter int NUM_IN    = 30,
  parameter int NUM_NODES = 16,
  parameter int ACT_AW    = 5,
  parameter int W_AW      = 10,
  parameter int NODE_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ACT_AW-1:0] act_addr,
  input  logic [31:0]       act_data,
  output logic [W_AW-1:0]   w_addr,
  input  logic [31:0]       w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NODE_W-1:0] out_node,
  output logic [31:0]       out_data
);

  localparam int KW = $clog2(NUM_IN + 1);
  localparam logic [KW-1:0]     K_BIAS    = KW'(NUM_IN);
  localparam logic [KW-1:0]     K_LAST    = KW'(NUM_IN - 1);
  localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(NUM_NODES - 1);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t            state_reg;
  logic [NODE_W-1:0] node_reg;
  logic [KW-1:0]     k_reg;
  logic [KW-1:0]     data_k_reg;
  logic              issue_vld_reg;
  logic              data_vld_reg;
  logic [31:0]       acc_reg;
  logic [31:0]       addend;
  logic [31:0]       acc_next;
  logic [31:0]       result_next;

  // data_*_reg tags the word currently on act_data/w_data with the k it was issued for
  always_comb begin
    addend   = (data_k_reg == K_BIAS) ? w_data : act_data * w_data;
    acc_next = data_vld_reg ? acc_reg + addend : acc_reg;
    result_next = {16'b0, acc_next[28:13]};
`ifdef LAYER_SCHED_SAT_EN
    if (acc_next[30:29] != 2'b00) result_next = 32'h0000_FFFF;
`endif
    if (acc_next[31]) result_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      node_reg      <= '0;
      k_reg         <= '0;
      data_k_reg    <= '0;
      issue_vld_reg <= 1'b0;
      data_vld_reg  <= 1'b0;
      acc_reg       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      act_addr      <= '0;
      w_addr        <= '0;
      out_valid     <= 1'b0;
      out_node      <= '0;
      out_data      <= '0;
    end else begin
      done         <= 1'b0;
      data_vld_reg <= issue_vld_reg;
      data_k_reg   <= k_reg;
      acc_reg      <= acc_next;
      case (state_reg)
        IDLE: begin
          // a start coinciding with the done pulse is dropped
          if (start && !done) begin
            state_reg     <= MAC;
            busy          <= 1'b1;
            node_reg      <= '0;
            k_reg         <= '0;
            issue_vld_reg <= 1'b1;
            act_addr      <= '0;
            w_addr        <= '0;
            acc_reg       <= '0;
          end
        end
        MAC: begin
          if (k_reg == K_BIAS) begin
            issue_vld_reg <= 1'b0;
            state_reg     <= DRAIN;
          end else begin
            k_reg    <= k_reg + KW'(1);
            w_addr   <= w_addr + W_AW'(1);
            act_addr <= (k_reg == K_LAST) ? '0 : act_addr + ACT_AW'(1);
          end
        end
        DRAIN: begin
          state_reg <= OUT;
          out_valid <= 1'b1;
          out_data  <= result_next;
          out_node  <= node_reg;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (node_reg == NODE_LAST) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              // weights are laid out node-major, so the next node's k=0 follows the bias word
              node_reg      <= node_reg + NODE_W'(1);
              k_reg         <= '0;
              issue_vld_reg <= 1'b1;
              act_addr      <= '0;
              w_addr        <= w_addr + W_AW'(1);
              acc_reg       <= '0;
              state_reg     <= MAC;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Self-checking bench for layer_mac_scheduler (NUM_IN=4, NUM_NODES=2): table vectors, corner sequences, random runs.
module tb_layer_mac_scheduler;

  localparam int NI = 4;
  localparam int NN = 2;
  localparam int ACT_AW = 5;
  localparam int W_AW = 10;
  localparam int NODE_W = 4;
  localparam int NW = NN * (NI + 1);

`ifdef LAYER_SCHED_SAT_EN
  localparam logic [31:0] SATV = 32'h0000_FFFF;
`else
  localparam logic [31:0] SATV = 32'h0000_0000;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [ACT_AW-1:0] act_addr;
  logic [31:0]       act_data;
  logic [W_AW-1:0]   w_addr;
  logic [31:0]       w_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [NODE_W-1:0] out_node;
  logic [31:0]       out_data;

  layer_mac_scheduler #(
    .NUM_IN(NI), .NUM_NODES(NN), .ACT_AW(ACT_AW), .W_AW(W_AW), .NODE_W(NODE_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .act_addr(act_addr), .act_data(act_data), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_node(out_node), .out_data(out_data)
  );

  always #5 clk = ~clk;

  logic [31:0] act_mem [0:(1<<ACT_AW)-1];
  logic [31:0] w_mem   [0:(1<<W_AW)-1];

  always @(posedge clk) begin
    act_data <= act_mem[act_addr];
    w_data   <= w_mem[w_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct { int node; int data; int cyc; } acc_t;
  acc_t acc_q[$];
  int   done_q[$];
  bit   ready_hist [0:1023];
  bit   mon_on = 1'b0;
  bit   addr_chk = 1'b0;
  int   s0 = 0;
  logic              prev_v, prev_r;
  logic [31:0]       prev_d;
  logic [NODE_W-1:0] prev_n;
  logic [W_AW-1:0]   prev_w;

  // Observes the DUT at mid-cycle; cycle c is the period after the c-th edge following start
  always @(negedge clk) begin : mon
    int c, j, n;
    if (mon_on) begin
      c = cyc - s0;
      if (out_valid && out_ready) acc_q.push_back('{int'(out_node), int'(out_data), c});
      if (done) done_q.push_back(c);
      if (c == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, prev_d);
        check("hold_node", 32'(out_node), 32'(prev_n));
        check("hold_w_addr", 32'(w_addr), 32'(prev_w));
      end
      if (addr_chk && c >= 1 && c <= NN * (NI + 3)) begin
        j = (c - 1) % (NI + 3);
        n = (c - 1) / (NI + 3);
        if (j <= NI) check("w_addr_seq", 32'(w_addr), 32'(n * (NI + 1) + j));
        if (j < NI) check("act_addr_seq", 32'(act_addr), 32'(j));
      end
      if (done_q.size() > 0 && c == done_q[0] + 1) check("idle_after_done", 32'(busy), 32'd0);
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
      prev_n = out_node;
      prev_w = w_addr;
    end
  end

  task automatic chk_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_node"}, 32'(out_node), 32'd0);
    check({tag, "_act_addr"}, 32'(act_addr), 32'd0);
    check({tag, "_w_addr"}, 32'(w_addr), 32'd0);
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for cycles 7..11
  task automatic run_layer(input int mode, input int extra_start, input int rst_cyc, input bit achk);
    int c;
    bit fin;
    acc_q.delete();
    done_q.delete();
    for (int i = 0; i < 1024; i++) ready_hist[i] = 1'b0;
    @(posedge clk); #1;
    s0 = cyc;
    addr_chk = achk;
    prev_v = 1'b0;
    prev_r = 1'b0;
    mon_on = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    ready_hist[0] = 1'b1;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      c = cyc - s0;
      start = (c == extra_start);
      reset = !(c == rst_cyc);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(c >= 7 && c < 12);
      endcase
      if (c < 1024) ready_hist[c] = out_ready;
      if (done_q.size() > 0 && c >= done_q[0] + 3) fin = 1'b1;
      if (rst_cyc >= 0 && c >= rst_cyc + 6) fin = 1'b1;
      if (c >= 900) begin
        fin = 1'b1;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: no done after %0d cycles, expected done", c);
      end
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        @(negedge clk);
        chk_reset_state("midop_reset");
      end
    end
    mon_on = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic verify(input logic [31:0] e [NN], input int exp_done);
    int t;
    int ec [NN];
    t = 0;
    for (int n = 0; n < NN; n++) begin
      t += NI + 3;
      while (t < 1023 && !ready_hist[t]) t++;
      ec[n] = t;
    end
    check("result_count", 32'(acc_q.size()), 32'(NN));
    for (int n = 0; n < NN && n < acc_q.size(); n++) begin
      check("out_node", 32'(acc_q[n].node), 32'(n));
      check("out_data", 32'(acc_q[n].data), e[n]);
      check("accept_cycle", 32'(acc_q[n].cyc), 32'(ec[n]));
    end
    check("done_count", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) begin
      check("done_cycle", 32'(done_q[0]), 32'(ec[NN-1] + 1));
      if (exp_done >= 0) check("done_abs", 32'(done_q[0]), 32'(exp_done));
    end
  endtask

  // Reference: dot product plus bias in wrapping 32-bit arithmetic, then ReLU and Q-slice
  function automatic logic [31:0] model(input int n);
    int acc;
    acc = 0;
    for (int k = 0; k < NI; k++) acc += int'(act_mem[k]) * int'(w_mem[n * (NI + 1) + k]);
    acc += int'(w_mem[n * (NI + 1) + NI]);
    if (acc < 0) return 32'd0;
`ifdef LAYER_SCHED_SAT_EN
    if (acc >= 32'sh2000_0000) return 32'h0000_FFFF;
`endif
    return 32'(acc / 8192) & 32'h0000_FFFF;
  endfunction

  typedef struct packed {
    logic [0:NI-1][31:0] act;
    logic [0:NW-1][31:0] w;
    logic [0:NN-1][31:0] exp;
  } vec_t;

  localparam logic [31:0] P = 32'd8192;
  localparam logic [31:0] M = 32'hFFFF_E000;
  localparam logic [31:0] Z = 32'd0;

  vec_t vt [6];

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < NI; k++) act_mem[k] = v.act[k];
    for (int i = 0; i < NW; i++) w_mem[i] = v.w[i];
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e [NN];
    for (int i = 0; i < (1 << ACT_AW); i++) act_mem[i] = '0;
    for (int i = 0; i < (1 << W_AW); i++) w_mem[i] = '0;

    vt[0] = '{act: {32'd1, 32'd1, 32'd1, 32'd1},
              w:   {P, P, P, P, P, M, M, M, M, Z},
              exp: {32'd5, 32'd0}};
    vt[1] = '{act: {32'd1, Z, Z, Z},
              w:   {32'h2000_0000, Z, Z, Z, Z, Z, Z, Z, Z, Z},
              exp: {SATV, 32'd0}};
    vt[2] = '{act: {32'd2, 32'd3, 32'hFFFF_FFFF, Z},
              w:   {P, P, P, Z, Z, Z, Z, Z, Z, 32'd57344},
              exp: {32'd4, 32'd7}};
    vt[3] = '{act: {32'd5, 32'd6, 32'd7, 32'd8},
              w:   {Z, Z, Z, Z, 32'h1FFF_FFFF, Z, Z, Z, Z, 32'hFFFF_FFFF},
              exp: {32'h0000_FFFF, 32'd0}};
    vt[4] = '{act: {32'h0001_0000, 32'hFFFF_FFFD, Z, Z},
              w:   {32'h0001_0000, Z, Z, Z, 32'd24576, Z, M, Z, Z, Z},
              exp: {32'd3, 32'd3}};
    vt[5] = '{act: {32'd1, 32'd1, 32'd1, 32'd1},
              w:   {Z, Z, Z, Z, 32'd8191, Z, Z, Z, Z, P},
              exp: {32'd0, 32'd1}};

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("por");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      load_vec(vt[i]);
      run_layer(0, -1, -1, 1'b1);
      for (int n = 0; n < NN; n++) e[n] = vt[i].exp[n];
      verify(e, -1);
      $display("vector %0d: results %0d, node0 exp 0x%0h, node1 exp 0x%0h", i, acc_q.size(), e[0], e[1]);
    end

    load_vec(vt[0]);
    for (int n = 0; n < NN; n++) e[n] = vt[0].exp[n];

    run_layer(0, -1, -1, 1'b1);
    verify(e, 15);
    $display("basic run: done at cycle %0d", done_q.size() > 0 ? done_q[0] : -1);

    run_layer(2, -1, -1, 1'b0);
    verify(e, 20);
    $display("back-pressure run: done at cycle %0d", done_q.size() > 0 ? done_q[0] : -1);

    run_layer(0, 4, -1, 1'b1);
    verify(e, 15);
    $display("start-while-busy run: done at cycle %0d", done_q.size() > 0 ? done_q[0] : -1);

    run_layer(0, 15, -1, 1'b1);
    verify(e, 15);
    $display("start-with-done run: done at cycle %0d", done_q.size() > 0 ? done_q[0] : -1);

    run_layer(0, -1, 10, 1'b0);
    check("midop_result_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("midop_node0_data", 32'(acc_q[0].data), 32'd5);
    check("midop_no_done", 32'(done_q.size()), 32'd0);
    $display("mid-op reset run: results %0d, done pulses %0d", acc_q.size(), done_q.size());

    run_layer(0, -1, -1, 1'b1);
    verify(e, 15);
    $display("run after reset: node0 0x%0h", acc_q.size() > 0 ? acc_q[0].data : -1);

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < NI; k++)
        act_mem[k] = (it % 5 == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
      for (int i = 0; i < NW; i++)
        w_mem[i] = (it % 5 == 1) ? 32'($urandom) : 32'(int'($urandom_range(0, 65535)) - 16384);
      for (int n = 0; n < NN; n++) e[n] = model(n);
      run_layer((it % 2 == 0) ? 1 : 0, -1, -1, 1'b0);
      verify(e, -1);
      $display("random %0d: node0 exp 0x%0h, node1 exp 0x%0h, done at %0d",
               it, e[0], e[1], done_q.size() > 0 ? done_q[0] : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
